// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder controller
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to hold WIDTH itself, the value it reaches on the final RUN cycle.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational 1-bit full adder built from two half adders
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    halfadder u_ha0 (.x(a),  .y(b),   .s(s1), .c(c1));
    halfadder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/halfadder.sv
// rtl/halfadder.sv - 1-bit half adder
module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_load;
    logic             bit_s;
    logic             bit_c;
    logic [CW-1:0]    cnt;
    logic             last;

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // a - b as a + ~b + 1; carry-out then means "no borrow".
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        s_nxt            = s_sh >> 1;
        s_nxt[WIDTH-1]   = bit_s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_nxt;
                    carry <= bit_c;
                    cnt   <= cnt + CW'(1);
                    // Result registers only move on the final bit so they hold the previous result meanwhile.
                    if (last) begin
                        sum  <= s_nxt;
                        cout <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add controller that sequences a single 1-bit adder cell (two halfadder instances plus a carry flop) over WIDTH cycles.
Accepts an operand pair through a valid/ready handshake and shifts operands LSB-first through the cell. Returns the WIDTH-bit sum and carry-out through a second valid/ready handshake.
Sits between a requester and downstream logic that trade throughput for minimal adder area.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled only on input handshake
b  input  WIDTH  operand B, sampled only on input handshake
cin  input  1  carry-in, sampled only on input handshake
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  registered carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; sum=0, cout=0, out_valid=0, busy=0; in_ready=1.
  - Internal shift registers, carry flop and counter cleared.
  - All inputs ignored while rst_n low.
- States: IDLE, RUN, DONE. in_ready=(state==IDLE), out_valid=(state==DONE), busy=(state!=IDLE).
- IDLE:
  - On in_valid&&in_ready: load A<=a, B<=b, carry<=cin, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Bit compute: s=A[0]^B[0]^carry; carry<=majority(A[0],B[0],carry).
  - Shifts: S shifts right with s inserted at MSB; A and B shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE, registering sum<=final S and cout<=final carry.
- DONE:
  - Hold sum/cout/out_valid stable until out_ready. On out_valid&&out_ready go to IDLE.
  - sum/cout keep the last result after the handshake.
- Latency and throughput:
  - Input handshake at edge t gives out_valid high from edge t+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (IDLE, WIDTH×RUN, DONE). No overlap of accept and deliver.
- WIDTH=1: RUN lasts exactly one cycle.
- Counter width is $clog2(WIDTH+1). No wrap is possible, because the exit condition is checked before overflow.
- in_valid during RUN/DONE: ignored, not queued. Requester must hold in_valid until in_ready.
- Reset mid-RUN or mid-DONE: operation aborted, no out_valid pulse, state IDLE immediately.
- out_ready high outside DONE has no effect.
- Arithmetic: modulo 2^WIDTH; cout is the true bit WIDTH of a+b+cin.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled on the input handshake.
  - sub=1 loads B<=~b and carry<=1 (cin ignored), so the result is a−b; cout=1 means no borrow.
  - sub=0 behaves as the base adder.
- Undefined: port absent, add only, identical timing either way.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant.
  - Counter-width function.
- One natural sub-module: full_adder_bit, combinational, built from two halfadder instances plus an OR for carry. The controller instantiates it once.
- The carry flop stays in the controller.

Test Plan:
1. Reset: rst_n low 3 cycles, released -> out_valid=0, sum=0x00, cout=0, busy=0, in_ready=1.
2. Basic add (WIDTH=8): a=0x35, b=0x4A, cin=0 accepted at edge t -> out_valid rises at t+8, sum=0x7F, cout=0.
3. Carry chain:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
4. Backpressure: out_ready low 5 cycles in DONE -> out_valid, sum, cout stable; in_ready=0; in_valid pulses with a=0x11 ignored; next result unaffected.
5. Reset mid-RUN: assert rst_n low at the 4th RUN cycle -> no out_valid; then a=0x02, b=0x03 -> sum=0x05, cout=0.
6. With SERIAL_ADDER_SUB_EN, sub=1:
   - a=0x10, b=0x01 -> sum=0x0F, cout=1.
   - a=0x01, b=0x02 -> sum=0xFF, cout=0.
